tow_referee: RTL and testbench
==============================

TOW_REFEREE -- requirements
Module: tow_referee

Interface
REQ-001 The block SHALL have parameter NUM_LIGHTS, default 9, meaning the playfield LED count (odd, 3..15).
REQ-002 The block SHALL have parameter WIN_SCORE, default 7, meaning the rounds needed to win the game (1..7).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 4, meaning the cycles the round-win display is held (>=1).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-006 The block SHALL have port left_press, input, 1, meaning a one-cycle pulse per left-player button release from the input conditioner.
REQ-007 The block SHALL have port right_press, input, 1, meaning a one-cycle pulse per right-player button release.
REQ-008 The block SHALL have port lights, output, NUM_LIGHTS, meaning the playfield; bit NUM_LIGHTS-1 is the leftmost LED.
REQ-009 The block SHALL have ports left_score and right_score, output, 3 each, meaning the rounds won by each player.
REQ-010 The block SHALL have port winner, output, 2, meaning the winner code (00 none, 01 left, 10 right, 11 unused).
REQ-011 The block SHALL have port game_over, output, 1, meaning the game has ended.

Function
REQ-012 The controller SHALL have the states PLAY, HOLD and DONE, with the position pos held as an index in 0..NUM_LIGHTS-1 and CENTER = (NUM_LIGHTS-1)/2.
REQ-013 In PLAY, lights SHALL be one-hot at bit pos, and winner SHALL be 00.
REQ-014 In PLAY, on left_press only with pos < NUM_LIGHTS-1, pos SHALL increment by 1, with lights updated on the next edge (one-cycle latency).
REQ-015 In PLAY, on right_press only with pos > 0, pos SHALL decrement by 1.
REQ-016 In PLAY, left_press and right_press asserted in the same cycle SHALL cancel, leaving pos, the scores and the state unchanged.
REQ-017 In PLAY, left_press only with pos == NUM_LIGHTS-1 SHALL be a left round win: left_score increments, winner = 01, and the state goes to HOLD.
REQ-018 In PLAY, right_press only with pos == 0 SHALL be a right round win: right_score increments, winner = 10, and the state goes to HOLD.
REQ-019 In HOLD, lights SHALL be all ones, winner SHALL hold the round winner, and both press inputs SHALL be ignored.
REQ-020 HOLD SHALL last exactly HOLD_CYCLES cycles.
REQ-021 On leaving HOLD with the winner's score < WIN_SCORE, pos SHALL be set to CENTER, winner SHALL be set to 00, and the state SHALL go to PLAY.
REQ-022 On leaving HOLD with the winner's score == WIN_SCORE, the state SHALL go to DONE.
REQ-023 In DONE, game_over SHALL be 1, lights SHALL be all zeros, winner and the scores SHALL be held, and the presses SHALL be ignored until reset.
REQ-024 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-025 game_over SHALL be 0 in PLAY and HOLD.

Reset
REQ-026 reset SHALL be sampled at posedge clk only and SHALL override all other inputs in that cycle.
REQ-027 After reset, the block SHALL be in state PLAY with pos = CENTER, lights = one-hot at CENTER (000010000 for the default), both scores = 0, winner = 00, game_over = 0, and the hold counter = 0.
REQ-028 Reset asserted in any state, including mid-HOLD and in DONE, SHALL give the REQ-027 values on the following cycle.

Structure
REQ-029 Package tow_pkg SHALL hold the state enum (PLAY/HOLD/DONE) and the winner codes (WIN_NONE, WIN_LEFT, WIN_RIGHT).
REQ-030 Sub-module tow_hold_timer SHALL implement the hold counter: it loads on start, asserts done after HOLD_CYCLES cycles, and clears on reset.
REQ-031 lights SHALL be decoded combinationally from state and pos; state, pos, scores and winner SHALL be registered.

Verification
REQ-032 The bench SHALL apply reset, then 4 single left_press pulses, and SHALL see lights = 100000000 and no score change.
REQ-033 From pos 8, the bench SHALL apply one left_press and SHALL see left_score = 1 and winner = 01 for 4 cycles with lights all ones; on the next cycle lights = 000010000 and winner = 00.
REQ-034 From CENTER, the bench SHALL apply left_press and right_press in the same cycle and SHALL see lights unchanged at 000010000.
REQ-035 The bench SHALL apply presses during HOLD and SHALL see no change to pos or scores, and the hold length SHALL stay at exactly 4 cycles.
REQ-036 With WIN_SCORE = 2, the bench SHALL have the right player win 2 rounds and SHALL see game_over = 1, winner = 10, lights = 0, and further presses ignored.
REQ-037 The bench SHALL assert reset mid-HOLD and SHALL see all outputs at the REQ-027 values on the following cycle.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war referee: controller states and winner codes.
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'b00,
        HOLD = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_t;

endpackage

// File: rtl/tow_hold_timer.sv
// Down-counter that times the round-win display. A start pulse loads it, and
// done rises once HOLD_CYCLES cycles have elapsed since the load edge.
module tow_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    // Load on start, then count down to zero and rest there until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/tow_referee.sv
// Tug-of-war referee: tracks the rope position from the two players' button
// pulses, scores rounds, shows a round-win flash and ends the game at WIN_SCORE.
module tow_referee
    import tow_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  left_press,
    input  logic                  right_press,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [2:0]            left_score,
    output logic [2:0]            right_score,
    output logic [1:0]            winner,
    output logic                  game_over
);

    localparam int PW = $clog2(NUM_LIGHTS);
    localparam logic [PW-1:0] CENTER  = PW'((NUM_LIGHTS - 1) / 2);
    localparam logic [PW-1:0] MAX_POS = PW'(NUM_LIGHTS - 1);
    localparam logic [2:0]    WIN     = 3'(WIN_SCORE);
    localparam logic [NUM_LIGHTS-1:0] ONE_LIGHT = NUM_LIGHTS'(1);

    state_t        state;
    logic [PW-1:0] pos;
    logic [2:0]    left_count;
    logic [2:0]    right_count;
    winner_t       round_winner;

    logic          left_only;
    logic          right_only;
    logic          left_wins;
    logic          right_wins;
    logic          hold_done;
    logic [2:0]    round_score;

    // Simultaneous presses cancel, so only exclusive presses move the rope.
    assign left_only   = left_press & ~right_press;
    assign right_only  = right_press & ~left_press;
    assign left_wins   = (state == PLAY) && left_only && (pos == MAX_POS);
    assign right_wins  = (state == PLAY) && right_only && (pos == '0);
    assign round_score = (round_winner == WIN_LEFT) ? left_count : right_count;

    tow_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .start(left_wins | right_wins),
        .done (hold_done)
    );

    // Main controller: rope position, round scoring, flash hold and game end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PLAY;
            pos          <= CENTER;
            left_count   <= '0;
            right_count  <= '0;
            round_winner <= WIN_NONE;
        end else begin
            case (state)
                PLAY: begin
                    if (left_only) begin
                        if (pos == MAX_POS) begin
                            if (left_count < WIN) begin
                                left_count <= left_count + 3'd1;
                            end
                            round_winner <= WIN_LEFT;
                            state        <= HOLD;
                        end else begin
                            pos <= pos + PW'(1);
                        end
                    end else if (right_only) begin
                        if (pos == '0) begin
                            if (right_count < WIN) begin
                                right_count <= right_count + 3'd1;
                            end
                            round_winner <= WIN_RIGHT;
                            state        <= HOLD;
                        end else begin
                            pos <= pos - PW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        if (round_score >= WIN) begin
                            state <= DONE;
                        end else begin
                            pos          <= CENTER;
                            round_winner <= WIN_NONE;
                            state        <= PLAY;
                        end
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

    // Playfield decode: rope marker in play, full flash in hold, dark when done.
    always_comb begin
        lights = '0;
        case (state)
            PLAY:    lights = ONE_LIGHT << pos;
            HOLD:    lights = '1;
            default: lights = '0;
        endcase
    end

    assign left_score  = left_count;
    assign right_score = right_count;
    assign winner      = round_winner;
    assign game_over   = (state == DONE);

endmodule

// File: tb/tb_tow_referee.sv
// Self-checking bench for tow_referee: directed scenarios followed by random
// presses and resets, every cycle compared against a behavioural game model.
module tb_tow_referee;

    localparam int N      = 9;
    localparam int WINS   = 2;
    localparam int HOLD   = 4;
    localparam int CENTER = (N - 1) / 2;

    logic         clk;
    logic         reset;
    logic         left_press;
    logic         right_press;
    logic [N-1:0] lights;
    logic [2:0]   left_score;
    logic [2:0]   right_score;
    logic [1:0]   winner;
    logic         game_over;

    int checks;
    int fails;

    // Behavioural game model: rope position, scores, flash countdown, game end.
    int m_pos;
    int m_left;
    int m_right;
    int m_winner;
    int m_hold;
    bit m_done;

    tow_referee #(
        .NUM_LIGHTS (N),
        .WIN_SCORE  (WINS),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .left_press (left_press),
        .right_press(right_press),
        .lights     (lights),
        .left_score (left_score),
        .right_score(right_score),
        .winner     (winner),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic modelStep(input bit l, input bit r, input bit rst);
        int score;
        if (rst) begin
            m_pos = CENTER; m_left = 0; m_right = 0;
            m_winner = 0; m_hold = 0; m_done = 1'b0;
        end else if (m_done) begin
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) begin
                score = (m_winner == 1) ? m_left : m_right;
                if (score == WINS) begin
                    m_done = 1'b1;
                end else begin
                    m_pos = CENTER;
                    m_winner = 0;
                end
            end
        end else if (l && !r) begin
            if (m_pos == N - 1) begin
                m_left = m_left + 1; m_winner = 1; m_hold = HOLD;
            end else begin
                m_pos = m_pos + 1;
            end
        end else if (r && !l) begin
            if (m_pos == 0) begin
                m_right = m_right + 1; m_winner = 2; m_hold = HOLD;
            end else begin
                m_pos = m_pos - 1;
            end
        end
    endtask

    function automatic logic [31:0] expectedLights();
        if (m_done) return 32'd0;
        if (m_hold > 0) return (32'd1 << N) - 32'd1;
        return 32'd1 << m_pos;
    endfunction

    // Drive one cycle of inputs, step the model, then compare every output.
    task automatic applyStimulus(input bit l, input bit r, input bit rst);
        @(negedge clk);
        left_press  = l;
        right_press = r;
        reset       = rst;
        @(posedge clk);
        modelStep(l, r, rst);
        #1;
        checkOutput("lights",      32'(lights),      expectedLights());
        checkOutput("left_score",  32'(left_score),  32'(m_left));
        checkOutput("right_score", 32'(right_score), 32'(m_right));
        checkOutput("winner",      32'(winner),      32'(m_winner));
        checkOutput("game_over",   32'(game_over),   32'(m_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset = 1'b1; left_press = 1'b0; right_press = 1'b0;
        m_pos = CENTER; m_left = 0; m_right = 0; m_winner = 0; m_hold = 0; m_done = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_lights", 32'(lights), 32'h010);
        checkOutput("reset_winner", 32'(winner), 32'd0);

        $display("[TB] four left presses to the edge");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            idle(1);
        end
        checkOutput("edge_lights", 32'(lights), 32'h100);
        checkOutput("edge_left_score", 32'(left_score), 32'd0);

        $display("[TB] left round win with presses during hold");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("hold1_lights", 32'(lights), 32'h1FF);
        checkOutput("hold1_winner", 32'(winner), 32'd1);
        checkOutput("hold1_left_score", 32'(left_score), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("hold4_lights", 32'(lights), 32'h1FF);
        checkOutput("hold4_left_score", 32'(left_score), 32'd1);
        idle(1);
        checkOutput("after_hold_lights", 32'(lights), 32'h010);
        checkOutput("after_hold_winner", 32'(winner), 32'd0);

        $display("[TB] simultaneous presses cancel");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("cancel_lights", 32'(lights), 32'h010);

        $display("[TB] reset in the middle of hold");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("mid_hold_lights", 32'(lights), 32'h1FF);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_hold_lights", 32'(lights), 32'h010);
        checkOutput("rst_hold_right", 32'(right_score), 32'd0);
        checkOutput("rst_hold_left", 32'(left_score), 32'd0);
        checkOutput("rst_hold_winner", 32'(winner), 32'd0);
        idle(HOLD + 1);
        checkOutput("rst_hold_stays", 32'(lights), 32'h010);

        $display("[TB] right player wins the game");
        for (int round = 0; round < WINS; round++) begin
            for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
            idle(HOLD);
        end
        checkOutput("done_game_over", 32'(game_over), 32'd1);
        checkOutput("done_winner", 32'(winner), 32'd2);
        checkOutput("done_lights", 32'(lights), 32'd0);
        checkOutput("done_right_score", 32'(right_score), 32'd2);
        for (int i = 0; i < 6; i++) applyStimulus(i[0], ~i[0], 1'b0);
        checkOutput("done_ignored_score", 32'(right_score), 32'd2);
        checkOutput("done_ignored_over", 32'(game_over), 32'd1);

        $display("[TB] randomized play");
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            applyStimulus(sel < 5, (sel >= 4) && (sel < 7), $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
